// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd2,
    OP_MUL = 4'd4,
    OP_DIV = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between an operand source, the ALU and a result consumer.
interface alu_seq_if #(parameter int WIDTH = 8);

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in1;
  logic [WIDTH-1:0]       in2;
  logic [3:0]             op;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     out;
  logic [WIDTH-1:0]       rem;
  logic                   zero;
  logic                   error;

  modport master (
    output in_valid, in1, in2, op, out_ready,
    input  in_ready, out_valid, out, rem, zero, error
  );

  modport slave (
    input  in_valid, in1, in2, op, out_ready,
    output in_ready, out_valid, out, rem, zero, error
  );

endinterface

// File: rtl/alu_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle. The first step is taken on the
// start edge itself using the fresh operands, so done pulses WIDTH-1 cycles after start.
module alu_div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d, src_cnt;
  logic [WIDTH-1:0] quo_q, quo_d, src_quo;
  logic [WIDTH-1:0] rem_q, rem_d, src_rem;
  logic [WIDTH-1:0] dvs_q, dvs_d, src_dvs;
  logic [WIDTH:0]   shifted;

  // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
  always_comb begin
    src_rem = start ? '0       : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor  : dvs_q;
    src_cnt = start ? '0       : cnt_q;
    shifted = {src_rem, src_quo[WIDTH-1]};
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    if (start || busy_q) begin
      dvs_d = src_dvs;
      cnt_d = src_cnt + CW'(1);
      if (shifted >= {1'b0, src_dvs}) begin
        rem_d = WIDTH'(shifted - {1'b0, src_dvs});
        quo_d = {src_quo[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {src_quo[WIDTH-2:0], 1'b0};
      end
      if (src_cnt == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end
  end

  // Divider state registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential signed ALU: single-cycle add/sub/mul, iterative div with remainder,
// valid/ready on both sides and registered results held until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     nreset,
  alu_seq_if.slave bus
);

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               zero_q, zero_d;
  logic               error_q, error_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;

  logic               in_ready, accept, div_start, div_busy, div_done;
  logic [WIDTH-1:0]   a_mag, b_mag, div_quo, div_rem, rem_res;
  logic [WIDTH:0]     sum_w, dif_w;
  logic [2*WIDTH-1:0] prod_w, quo_ext, quo_res;

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // Add/sub one bit wider than the operands so they never overflow; mul keeps the full product.
  assign sum_w  = {bus.in1[WIDTH-1], bus.in1} + {bus.in2[WIDTH-1], bus.in2};
  assign dif_w  = {bus.in1[WIDTH-1], bus.in1} - {bus.in2[WIDTH-1], bus.in2};
  assign prod_w = {{WIDTH{bus.in1[WIDTH-1]}}, bus.in1} * {{WIDTH{bus.in2[WIDTH-1]}}, bus.in2};

  // Divider works on magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned.
  assign a_mag = bus.in1[WIDTH-1] ? ({WIDTH{1'b0}} - bus.in1) : bus.in1;
  assign b_mag = bus.in2[WIDTH-1] ? ({WIDTH{1'b0}} - bus.in2) : bus.in2;

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend.
  assign quo_ext = {{WIDTH{1'b0}}, div_quo};
  assign quo_res = q_neg_q ? ({2*WIDTH{1'b0}} - quo_ext) : quo_ext;
  assign rem_res = r_neg_q ? ({WIDTH{1'b0}} - div_rem) : div_rem;

  alu_div_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .nreset    (nreset),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Handshake FSM and next-result computation.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    rem_d       = rem_q;
    zero_d      = zero_q;
    error_d     = error_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    div_start   = 1'b0;
    case (state_q)
      DIV_BUSY: begin
        if (div_done && !div_busy) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_d       = quo_res;
          rem_d       = rem_res;
          zero_d      = (quo_res == '0);
          error_d     = 1'b0;
        end
      end
      IDLE, DONE: begin
        if (state_q == DONE && bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          error_d     = 1'b0;
          rem_d       = '0;
          case (bus.op)
            OP_ADD: out_d = {{(WIDTH-1){sum_w[WIDTH]}}, sum_w};
            OP_SUB: out_d = {{(WIDTH-1){dif_w[WIDTH]}}, dif_w};
            OP_MUL: out_d = prod_w;
            OP_DIV: begin
              if (bus.in2 == '0) begin
                error_d = 1'b1;
                out_d   = '0;
              end else begin
                state_d     = DIV_BUSY;
                out_valid_d = 1'b0;
                div_start   = 1'b1;
                q_neg_d     = bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
                r_neg_d     = bus.in1[WIDTH-1];
              end
            end
            default: begin
              error_d = 1'b1;
              out_d   = '0;
            end
          endcase
          zero_d = ~error_d & (out_d == '0);
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Result and state registers; results stay frozen while the consumer stalls.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rem_q       <= '0;
      zero_q      <= 1'b0;
      error_q     <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      rem_q       <= rem_d;
      zero_q      <= zero_d;
      error_q     <= error_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.rem       = rem_q;
  assign bus.zero      = zero_q;
  assign bus.error     = error_q;

endmodule
